// File: rtl/mda_timing_gen_if.sv
// MDA timing generator video bundle.
// master: generator side (drives timing/video, reads mode/ext_pixel); slave: consumer side.
interface mda_timing_gen_if #(
   parameter int CW = 10
);
   logic [1:0]    mode;
   logic          ext_pixel;
   logic          pix_ce;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          valid;
   logic          video;
   logic          hsync;
   logic          vsync;
   logic          newline;
   logic          newframe;
   logic [7:0]    frame_cnt;

   modport master (
      input  mode, ext_pixel,
      output pix_ce, x, y, valid, video,
      output hsync, vsync, newline, newframe, frame_cnt
   );

   modport slave (
      output mode, ext_pixel,
      input  pix_ce, x, y, valid, video,
      input  hsync, vsync, newline, newframe, frame_cnt
   );
endinterface

// File: rtl/mda_timing_gen.sv
// MDA raster timing generator: phase-accumulator pixel enable, x/y counters,
// sync/valid decode and test patterns. Ports: clk, rst (sync, high), vid bundle.
module mda_timing_gen #(
   parameter int              H_ACTIVE  = 720,
   parameter int              H_FP      = 10,
   parameter int              H_SYNC    = 135,
   parameter int              H_TOTAL   = 882,
   parameter int              V_ACTIVE  = 350,
   parameter int              V_FP      = 0,
   parameter int              V_SYNC    = 16,
   parameter int              V_TOTAL   = 370,
   parameter int              ACC_W     = 32,
   parameter logic [ACC_W-1:0] PHASE_INC = ACC_W'(1396465667),
   parameter int              BORDER    = 10,
   parameter bit              HS_POL    = 1'b1,
   parameter bit              VS_POL    = 1'b1,
   parameter int              CW        = 10
) (
   input logic             clk,
   input logic             rst,
   mda_timing_gen_if.master vid
);
   localparam logic [CW-1:0] XLAST  = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
   localparam logic [CW-1:0] HS_ON  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] XBL    = CW'(BORDER);
   localparam logic [CW-1:0] XBR    = CW'(H_ACTIVE - BORDER);
   localparam logic [CW-1:0] YLAST  = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
   localparam logic [CW-1:0] VS_ON  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] YBR    = CW'(V_ACTIVE - BORDER);

   logic [ACC_W-1:0] acc_q;
   logic             pix_ce_q;
   logic [CW-1:0]    x_q, x_d;
   logic [CW-1:0]    y_q, y_d;
   logic [7:0]       fcnt_q, fcnt_d;
   logic [1:0]       mode_q, mode_d;
   logic             valid_q, video_q, hs_q, vs_q;
   logic             nl_q, nf_q;
   logic             nl_d, nf_d;
   logic             valid_d, video_d, hs_d, vs_d;
   logic             border_d, pat_d;
   logic [ACC_W:0]   sum;
   logic             ce;

   assign sum = {1'b0, acc_q} + {1'b0, PHASE_INC};
   // Counters advance on the same edge that loads pix_ce=1, so the
   // new pixel is visible exactly in the pix_ce cycle.
   assign ce  = sum[ACC_W];

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      fcnt_d = fcnt_q;
      mode_d = mode_q;
      nl_d   = 1'b0;
      nf_d   = 1'b0;
      if (ce) begin
         if (x_q == XLAST) begin
            x_d  = '0;
            nl_d = 1'b1;
            if (y_q == YLAST) begin
               y_d    = '0;
               nf_d   = 1'b1;
               fcnt_d = fcnt_q + 8'd1;
            end else begin
               y_d = y_q + CW'(1);
            end
         end else begin
            x_d = x_q + CW'(1);
         end
         // Pattern select only latches on entry to (0,0).
         if (x_d == '0 && y_d == '0) mode_d = vid.mode;
      end
   end

   // Decode from next-state x/y so every registered output matches x/y.
   always_comb begin
      valid_d  = (x_d < HA) && (y_d < VA);
      hs_d     = (x_d >= HS_ON && x_d < HS_OFF) ? HS_POL : ~HS_POL;
      vs_d     = (y_d >= VS_ON && y_d < VS_OFF) ? VS_POL : ~VS_POL;
      border_d = (x_d < XBL) || (x_d >= XBR) ||
                 (y_d < XBL) || (y_d >= YBR);
      pat_d    = 1'b0;
      unique case (1'b1)
         (mode_d == 2'd1): pat_d = border_d;
         (mode_d == 2'd2): pat_d = x_d[3] ^ y_d[3];
         (mode_d == 2'd3): pat_d = vid.ext_pixel;
         default:          pat_d = 1'b0;
      endcase
      video_d = valid_d & pat_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         pix_ce_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         fcnt_q   <= '0;
         mode_q   <= vid.mode;
         video_q  <= 1'b0;
         valid_q  <= 1'b1;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
         nl_q     <= 1'b1;
         nf_q     <= 1'b1;
      end else begin
         acc_q    <= sum[ACC_W-1:0];
         pix_ce_q <= ce;
         nl_q     <= nl_d;
         nf_q     <= nf_d;
         mode_q   <= mode_d;
         if (ce) begin
            x_q     <= x_d;
            y_q     <= y_d;
            fcnt_q  <= fcnt_d;
            valid_q <= valid_d;
            video_q <= video_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
         end
      end
   end

   assign vid.pix_ce    = pix_ce_q;
   assign vid.x         = x_q;
   assign vid.y         = y_q;
   assign vid.valid     = valid_q;
   assign vid.video     = video_q;
   assign vid.hsync     = hs_q;
   assign vid.vsync     = vs_q;
   assign vid.newline   = nl_q;
   assign vid.newframe  = nf_q;
   assign vid.frame_cnt = fcnt_q;
endmodule

// File: tb/tb_mda_timing_gen.sv
// Self-checking bench for mda_timing_gen: small-raster instance for
// patterns/frames/reset, default instances for cadence, line length, hsync.
module tb_mda_timing_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_s, rst_d, rst_a;
   int   n_tests = 0;
   int   n_fail  = 0;

   mda_timing_gen_if #(.CW(10)) if_s ();
   mda_timing_gen_if #(.CW(10)) if_d ();
   mda_timing_gen_if #(.CW(10)) if_a ();

   // 50x36 raster, 40x30 active, inverted syncs, 0.375 pixel rate.
   mda_timing_gen #(
      .H_ACTIVE(40), .H_FP(2), .H_SYNC(6), .H_TOTAL(50),
      .V_ACTIVE(30), .V_FP(1), .V_SYNC(3), .V_TOTAL(36),
      .ACC_W(32), .PHASE_INC(32'h6000_0000), .BORDER(4),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(10)
   ) u_s (.clk(clk), .rst(rst_s), .vid(if_s));

   mda_timing_gen u_d (.clk(clk), .rst(rst_d), .vid(if_d));

   mda_timing_gen #(.PHASE_INC(32'h8000_0000))
      u_a (.clk(clk), .rst(rst_a), .vid(if_a));

   typedef struct {
      logic [1:0] mode;
      logic       ext;
      int         x;
      int         y;
      logic       valid;
      logic       video;
      logic       hs;
      logic       vs;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic [1:0] m, input logic e,
                      input int xx, input int yy,
                      input logic v, input logic d,
                      input logic h, input logic vv);
      vec_t t;
      t.mode = m; t.ext = e; t.x = xx; t.y = yy;
      t.valid = v; t.video = d; t.hs = h; t.vs = vv;
      tv.push_back(t);
   endtask

   task automatic chk(input string name, input longint act,
                      input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_xy(input int xx, input int yy, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         if (int'(if_s.x) == xx && int'(if_s.y) == yy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit ok;
      int nf, nl, vcnt, hcnt, vscnt, hold_err, pulse_err, first_hx;
      int px, py, pfc;
      logic pv, ph, pvs, pvd;
      logic [5:0] bits;
      int k, gap;
      int cnt, cons, vl, hl, hfirst, hlast;
      logic prev_ce;

      // frame 0: border (mode latched at reset)
      add(1, 0,  2,  0, 1, 1, 1, 1);
      add(1, 0, 20, 15, 1, 0, 1, 1);
      add(1, 0, 38, 29, 1, 1, 1, 1);
      add(1, 0, 20, 27, 1, 1, 1, 1);
      add(1, 0, 40,  5, 0, 0, 1, 1);
      add(1, 0, 43,  5, 0, 0, 0, 1);
      add(1, 0, 48,  5, 0, 0, 1, 1);
      // mode 2 requested mid-frame: border must persist
      add(2, 0, 20, 10, 1, 0, 1, 1);
      add(2, 0,  2, 12, 1, 1, 1, 1);
      add(2, 0, 10, 31, 0, 0, 1, 0);
      add(2, 0, 10, 34, 0, 0, 1, 1);
      // frame 1: checker
      add(2, 0,  1,  0, 1, 0, 1, 1);
      add(2, 0,  8,  0, 1, 1, 1, 1);
      add(2, 0,  8,  8, 1, 0, 1, 1);
      add(2, 0, 20, 15, 1, 1, 1, 1);
      // mode 3 requested mid-frame: checker must persist
      add(3, 1, 16, 20, 1, 0, 1, 1);
      add(3, 1, 45, 20, 0, 0, 0, 1);
      // frame 2: external pixel
      add(3, 1,  3,  0, 1, 1, 1, 1);
      add(3, 0, 30, 29, 1, 0, 1, 1);
      add(3, 1, 39, 29, 1, 1, 1, 1);
      add(3, 1, 40, 29, 0, 0, 1, 1);
      add(3, 1,  5, 30, 0, 0, 1, 1);
      add(0, 1,  5, 31, 0, 0, 1, 0);
      // frame 3: blank
      add(0, 1,  2,  2, 1, 0, 1, 1);

      rst_s = 1'b1; rst_d = 1'b1; rst_a = 1'b1;
      if_s.mode = 2'd1; if_s.ext_pixel = 1'b0;
      if_d.mode = 2'd0; if_d.ext_pixel = 1'b0;
      if_a.mode = 2'd0; if_a.ext_pixel = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst.x", if_s.x, 0);
      chk("rst.y", if_s.y, 0);
      chk("rst.valid", if_s.valid, 1);
      chk("rst.video", if_s.video, 0);
      chk("rst.hsync", if_s.hsync, 1);
      chk("rst.vsync", if_s.vsync, 1);
      chk("rst.newline", if_s.newline, 1);
      chk("rst.newframe", if_s.newframe, 1);
      chk("rst.frame_cnt", if_s.frame_cnt, 0);
      chk("rst.pix_ce", if_s.pix_ce, 0);

      rst_s = 1'b0;
      @(negedge clk);
      chk("start.ce1", if_s.pix_ce, 0);
      chk("start.newline", if_s.newline, 0);
      @(negedge clk);
      chk("start.ce2", if_s.pix_ce, 0);
      chk("start.x2", if_s.x, 0);
      @(negedge clk);
      chk("start.ce3", if_s.pix_ce, 1);
      chk("start.x3", if_s.x, 1);

      foreach (tv[i]) begin
         if_s.mode      = tv[i].mode;
         if_s.ext_pixel = tv[i].ext;
         wait_xy(tv[i].x, tv[i].y, ok);
         chk($sformatf("v%0d.reach", i), ok, 1);
         if (ok) begin
            chk($sformatf("v%0d.valid", i), if_s.valid, tv[i].valid);
            chk($sformatf("v%0d.video", i), if_s.video, tv[i].video);
            chk($sformatf("v%0d.hsync", i), if_s.hsync, tv[i].hs);
            chk($sformatf("v%0d.vsync", i), if_s.vsync, tv[i].vs);
         end
      end

      // two full frames from a fresh reset
      if_s.mode = 2'd2;
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      nf = 0; nl = 0; vcnt = 0; hcnt = 0; vscnt = 0;
      hold_err = 0; pulse_err = 0; first_hx = -1;
      px = 0; py = 0; pfc = 0;
      pv = 1'b1; ph = 1'b1; pvs = 1'b1; pvd = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         if (if_s.pix_ce) begin
            if (if_s.valid) vcnt++;
            if (!if_s.hsync) hcnt++;
            if (!if_s.vsync && if_s.x == 0) vscnt++;
            if (if_s.y == 0 && !if_s.hsync && first_hx < 0)
               first_hx = int'(if_s.x);
         end else begin
            if (int'(if_s.x) != px || int'(if_s.y) != py ||
                if_s.valid != pv || if_s.hsync != ph ||
                if_s.vsync != pvs || if_s.video != pvd ||
                int'(if_s.frame_cnt) != pfc)
               hold_err++;
            if (if_s.newline || if_s.newframe) pulse_err++;
         end
         if (if_s.newline && if_s.x != 0) pulse_err++;
         if (if_s.newframe && (if_s.x != 0 || if_s.y != 0))
            pulse_err++;
         if (if_s.newline) nl++;
         if (if_s.newframe) nf++;
         px = int'(if_s.x); py = int'(if_s.y);
         pfc = int'(if_s.frame_cnt);
         pv = if_s.valid; ph = if_s.hsync;
         pvs = if_s.vsync; pvd = if_s.video;
         if (nf == 2) break;
      end
      chk("frames.newframe", nf, 2);
      chk("frames.frame_cnt", if_s.frame_cnt, 2);
      chk("frames.valid_pix", vcnt, 2400);
      chk("frames.hsync_pix", hcnt, 432);
      chk("frames.vsync_lines", vscnt, 6);
      chk("frames.newline", nl, 72);
      chk("frames.hsync_x0", first_hx, 42);
      chk("frames.hold_err", hold_err, 0);
      chk("frames.pulse_err", pulse_err, 0);

      // mid-frame reset
      wait_xy(25, 20, ok);
      chk("midrst.reach", ok, 1);
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      chk("midrst.x", if_s.x, 0);
      chk("midrst.y", if_s.y, 0);
      chk("midrst.newline", if_s.newline, 1);
      chk("midrst.newframe", if_s.newframe, 1);
      chk("midrst.frame_cnt", if_s.frame_cnt, 0);
      chk("midrst.pix_ce", if_s.pix_ce, 0);

      // half-rate accumulator on the full-size raster
      rst_a = 1'b0;
      bits = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bits = {bits[4:0], if_a.pix_ce};
      end
      chk("half.cadence", bits, 6'b010101);
      k = 6;
      while (!if_a.newline && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk("half.first_line", k, 1764);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!if_a.newline && gap < 4000);
      chk("half.line_gap", gap, 1764);

      // default rate and line 1 decode
      rst_d = 1'b0;
      cnt = 0; cons = 0; vl = 0; hl = 0;
      hfirst = -1; hlast = -1; prev_ce = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (if_d.pix_ce) begin
            cnt++;
            if (prev_ce) cons++;
            if (if_d.y == 1) begin
               if (if_d.valid) vl++;
               if (if_d.hsync) begin
                  hl++;
                  if (hfirst < 0) hfirst = int'(if_d.x);
                  hlast = int'(if_d.x);
               end
            end
         end
         prev_ce = if_d.pix_ce;
      end
      chk("def.ce_count", cnt,
          (longint'(10000) * longint'(1396465667)) >>> 32);
      chk("def.ce_consec", cons, 0);
      chk("def.valid_line", vl, 720);
      chk("def.hsync_len", hl, 135);
      chk("def.hsync_first", hfirst, 730);
      chk("def.hsync_last", hlast, 864);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
